// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between the CPU store path
// (requester 0) and the debug/boot monitor (requester 1). Bytes are
// arbitrated round-robin into a small circular FIFO; a four-state sequencer
// pops each byte, strobes the UART, confirms the start, re-strobes on a
// missed start and drops the byte after too many attempts.
module uart_tx_sched #(
   parameter int DEPTH_LOG2    = 3,
   parameter int START_TIMEOUT = 15,
   parameter int MAX_RETRY     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_we,
   input  logic [7:0]            req0_data,
   output logic                  req0_ack,
   input  logic                  req1_we,
   input  logic [7:0]            req1_data,
   output logic                  req1_ack,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  uart_transmit,
   output logic [7:0]            uart_tx_byte,
   input  logic                  uart_is_transmitting,
   output logic                  busy,
   output logic                  err_drop
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int TW    = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
   localparam int RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(START_TIMEOUT);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [TW-1:0]         tcnt;
   logic [RW-1:0]         retry;
   logic                  last_grant;
   logic                  grant0;
   logic                  grant1;
   logic                  push;
   logic                  pop;
   logic [7:0]            push_data;

   // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign fifo_empty = (fifo_count == '0);

   // Round-robin grant: a lone requester wins, a contested cycle goes to the one not granted last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst && !fifo_full) begin
         if (req0_we && req1_we) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = req0_we;
            grant1 = req1_we;
         end
      end
   end

   assign req0_ack  = grant0;
   assign req1_ack  = grant1;
   assign push      = grant0 | grant1;
   assign push_data = grant0 ? req0_data : req1_data;

   // The sequencer only takes a byte while idle and the UART line is free.
   assign pop  = (state == IDLE) && !fifo_empty && !uart_is_transmitting;
   assign busy = (state != IDLE) || !fifo_empty;

   // FIFO storage: contents are not reset, only the pointers and count are.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // FIFO pointers, occupancy and round-robin history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         last_grant <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_grant <= grant1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + 1'b1;
         end else if (pop && !push) begin
            fifo_count <= fifo_count - 1'b1;
         end
      end
   end

   // Transmit sequencer: pop, strobe, confirm start (with retry/drop), wait for end of frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= 8'h00;
         err_drop      <= 1'b0;
         tcnt          <= '0;
         retry         <= '0;
      end else begin
         uart_transmit <= 1'b0;
         err_drop      <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  uart_tx_byte  <= mem[rd_ptr];
                  retry         <= '0;
                  uart_transmit <= 1'b1;
                  state         <= START;
               end
            end
            START: begin
               tcnt  <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (uart_is_transmitting) begin
                  state <= WAIT_DONE;
               end else if (tcnt == TIMEOUT_VAL) begin
                  if (retry == RETRY_LIMIT) begin
                     err_drop <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     retry         <= retry + 1'b1;
                     uart_transmit <= 1'b1;
                     state         <= START;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!uart_is_transmitting) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit scheduler that shares the single UART transmitter between two byte sources: requester 0 is the CPU store path via the 0xffff mem_io window, requester 1 is the debug/boot monitor.
- Arbitrates the two sources round-robin into a shared TX FIFO.
- Sequences the UART transmit strobe: one pulse per byte, with start confirmation, retry on a missed start, and end-of-frame detection.
- Sits between mem_io/monitor and the uart instance, replacing ad-hoc transmit toggling.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO entries (8 entries).
- START_TIMEOUT, 15, cycles to wait for uart_is_transmitting to rise after a strobe before re-strobing.
- MAX_RETRY, 3, re-strobe attempts before the byte is dropped and err_drop pulses.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- req0_we  input  1  requester 0 write request; held until req0_ack.
- req0_data  input  8  requester 0 byte.
- req0_ack  output  1  combinational; high in the cycle req0's byte is written.
- req1_we  input  1  requester 1 write request.
- req1_data  input  8  requester 1 byte.
- req1_ack  output  1  combinational; high in the cycle req1's byte is written.
- fifo_full  output  1  count == 2^DEPTH_LOG2.
- fifo_empty  output  1  count == 0.
- fifo_count  output  DEPTH_LOG2+1  registered occupancy.
- uart_transmit  output  1  one-cycle transmit strobe to uart.
- uart_tx_byte  output  8  registered byte to uart; stable from the strobe until end of frame.
- uart_is_transmitting  input  1  uart busy flag.
- busy  output  1  high when FSM is not IDLE or FIFO is not empty.
- err_drop  output  1  one-cycle pulse when a byte is dropped after MAX_RETRY.

Behaviour:
- Reset (rst low, asynchronous): FIFO pointers and count = 0; FSM = IDLE; uart_transmit = 0; uart_tx_byte = 8'h00; err_drop = 0; retry and timeout counters = 0; last_grant = 1, so req0 wins the first contested cycle; acks = 0.
- Reset mid-frame: FIFO contents are discarded. The uart is not reset by this block.

Arbitration:
- At most one push per cycle, only when fifo_full = 0, evaluated on the registered count.
- A pop in the same cycle does not make room.
- Only one requester active: it is granted.
- Both active: grant the one not equal to last_grant.
- last_grant updates only on a grant.
- ack = grant; data is written at the posedge ending the ack cycle.
- A requester still holding we after ack is treated as a new byte.

FIFO:
- Circular buffer; wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap naturally.
- Simultaneous push and pop: count unchanged.
- A pop is issued only by the FSM.

FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if fifo_empty = 0 and uart_is_transmitting = 0 → pop the head into uart_tx_byte, clear retry, go to START.
- START: uart_transmit = 1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY, uart_is_transmitting = 1: go to WAIT_DONE.
- WAIT_BUSY, timeout counter reaches START_TIMEOUT with retry < MAX_RETRY: retry++, go to START.
- WAIT_BUSY, timeout counter reaches START_TIMEOUT with retry == MAX_RETRY: pulse err_drop, go to IDLE.
- WAIT_DONE: when uart_is_transmitting = 0 → IDLE.

Latency and throughput:
- Byte accepted at cycle N into an empty FIFO with the FSM in IDLE: pop at N+1, uart_transmit high at N+2.
- Back-to-back bytes: the next strobe comes no earlier than 2 cycles after the uart_is_transmitting falling edge.
- uart_transmit is never high in two consecutive cycles.
- uart_tx_byte changes only on a pop.

Test Plan:
- Reset, then req0 writes 8'h41 once; uart busy 10 cycles after the strobe → req0_ack in cycle 0, uart_transmit pulse at cycle 2 with uart_tx_byte = 8'h41, busy clears after uart_is_transmitting falls.
- req0 and req1 both hold we continuously with 8'hA0 and 8'hB0 while the uart is stalled busy → acks alternate req0, req1, req0, ...; FIFO order A0, B0, A0, ...; the 8th push sets fifo_full; no ack while full.
- FIFO full and a pop occurs while req0 requests → no ack that cycle, fifo_count = 7 next cycle, ack in the following cycle.
- uart_is_transmitting held 0 after the strobe → re-strobes at START_TIMEOUT spacing, 4 strobes total, then an err_drop pulse; the next FIFO byte is sent.
- rst asserted low during WAIT_DONE with 3 bytes queued → immediately fifo_count = 0, uart_transmit = 0, FSM in IDLE; no further strobes after release.
- Push 20 bytes 0x00–0x13 through req1 with the uart modelling a 10-cycle frame → all 20 bytes emitted in order; pointers wrap correctly; no duplicates and no drops.
